// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle MSB-first magnitude comparator: DIGIT bits per clock, signed/unsigned, one-hot g/e/l.
// Optional macro CMP_EARLY_EXIT_EN: finish on the first differing slice instead of after all slices.
module seq_magnitude_comparator #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             g,
    output logic             e,
    output logic             l
);
    localparam int NSLICE = WIDTH / DIGIT;
    localparam int CW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);
    localparam logic [WIDTH-1:0] SIGN_BIT = {1'b1, {(WIDTH-1){1'b0}}};

    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("seq_magnitude_comparator: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    // Handshake: start is accepted on an edge where busy=0 (IDLE or DONE);
    // busy stays high until the result edge, and done pulses for the one cycle after it.
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    logic [WIDTH-1:0]  sa;
    logic [WIDTH-1:0]  sb;
    logic [CW-1:0]     cnt;
    logic [DIGIT-1:0]  slice_a;
    logic [DIGIT-1:0]  slice_b;
    logic              slice_ne;
    logic              slice_gt;

    assign slice_a  = sa[WIDTH-1 -: DIGIT];
    assign slice_b  = sb[WIDTH-1 -: DIGIT];
    assign slice_ne = (slice_a != slice_b);
    assign slice_gt = (slice_a > slice_b);

`ifndef CMP_EARLY_EXIT_EN
    // Verdict of the first differing slice; later slices must not override it.
    logic decided;
    logic decided_gt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            g     <= 1'b0;
            e     <= 1'b0;
            l     <= 1'b0;
            sa    <= '0;
            sb    <= '0;
            cnt   <= '0;
`ifndef CMP_EARLY_EXIT_EN
            decided    <= 1'b0;
            decided_gt <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        // Flipping the sign bit maps two's complement onto offset binary.
                        sa    <= a ^ (signed_mode ? SIGN_BIT : '0);
                        sb    <= b ^ (signed_mode ? SIGN_BIT : '0);
                        cnt   <= '0;
                        state <= RUN;
                        busy  <= 1'b1;
`ifndef CMP_EARLY_EXIT_EN
                        decided    <= 1'b0;
                        decided_gt <= 1'b0;
`endif
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                RUN: begin
`ifdef CMP_EARLY_EXIT_EN
                    if (slice_ne || cnt == LAST) begin
                        g     <= slice_ne & slice_gt;
                        l     <= slice_ne & ~slice_gt;
                        e     <= ~slice_ne;
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        sa  <= sa << DIGIT;
                        sb  <= sb << DIGIT;
                        cnt <= cnt + 1'b1;
                    end
`else
                    if (cnt == LAST) begin
                        if (decided) begin
                            g <= decided_gt;
                            l <= ~decided_gt;
                            e <= 1'b0;
                        end else begin
                            g <= slice_ne & slice_gt;
                            l <= slice_ne & ~slice_gt;
                            e <= ~slice_ne;
                        end
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        if (!decided && slice_ne) begin
                            decided    <= 1'b1;
                            decided_gt <= slice_gt;
                        end
                        sa  <= sa << DIGIT;
                        sb  <= sb << DIGIT;
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Directed bench for seq_magnitude_comparator (WIDTH=8, DIGIT=2) with immediate-assertion checks.
module tb_seq_magnitude_comparator;
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       signed_mode;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic       g;
    logic       e;
    logic       l;

    int vectors = 0;
    int miscompares = 0;

    seq_magnitude_comparator #(.WIDTH(8), .DIGIT(2)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
        .a(a), .b(b), .busy(busy), .done(done), .g(g), .e(e), .l(l)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int observed, input int expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    function automatic int pick_lat(input int early_lat);
`ifdef CMP_EARLY_EXIT_EN
        return early_lat;
`else
        return 4 + 0 * early_lat;
`endif
    endfunction

    // Starts a compare from the current cycle, scrambles the inputs afterwards, waits for done.
    task automatic run_cmp(input string tag, input logic [7:0] va, input logic [7:0] vb,
                           input logic sm, input int early_lat,
                           input int eg, input int ee, input int el);
        int n;
        start = 1'b1; a = va; b = vb; signed_mode = sm;
        step();
        start = 1'b0;
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(0, 255));
        signed_mode = 1'($urandom_range(0, 1));
        check({tag, "_busy"}, int'(busy), 1);
        n = 0;
        while (!done && n < 20) begin
            step();
            n++;
        end
        check({tag, "_lat"}, n, pick_lat(early_lat));
        check({tag, "_g"}, int'(g), eg);
        check({tag, "_e"}, int'(e), ee);
        check({tag, "_l"}, int'(l), el);
        check({tag, "_busy_done"}, int'(busy), 0);
    endtask

    initial begin
        int n;
        int pulses;
        rst = 1'b1; start = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
        step();
        step();
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_g", int'(g), 0);
        check("rst_e", int'(e), 0);
        check("rst_l", int'(l), 0);
        rst = 1'b0;
        step();

        run_cmp("eq_5a", 8'h5A, 8'h5A, 1'b0, 4, 0, 1, 0);
        step();
        run_cmp("c0_3f_u", 8'hC0, 8'h3F, 1'b0, 1, 1, 0, 0);
        step();
        run_cmp("c0_3f_s", 8'hC0, 8'h3F, 1'b1, 1, 0, 0, 1);
        step();
        run_cmp("12_13_u", 8'h12, 8'h13, 1'b0, 4, 0, 0, 1);
        step();
        run_cmp("ff_ff_s", 8'hFF, 8'hFF, 1'b1, 4, 0, 1, 0);
        step();
        run_cmp("01_ff_s", 8'h01, 8'hFF, 1'b1, 1, 1, 0, 0);
        step();
        run_cmp("01_ff_u", 8'h01, 8'hFF, 1'b0, 1, 0, 0, 1);
        step();

        // Second start while busy must be ignored: 0x80 vs 0x01 signed is -128 < 1.
        start = 1'b1; a = 8'h80; b = 8'h01; signed_mode = 1'b1;
        step();
        a = 8'h00; b = 8'h01;
        step();
        start = 1'b0;
        n = 1;
        while (!done && n < 20) begin
            step();
            n++;
        end
        check("ign_lat", n, pick_lat(1));
        check("ign_g", int'(g), 0);
        check("ign_e", int'(e), 0);
        check("ign_l", int'(l), 1);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (done || busy) pulses++;
        end
        check("ign_extra_activity", pulses, 0);

        // Back-to-back: start issued in the DONE cycle of the previous compare.
        run_cmp("b2b_first", 8'h40, 8'h80, 1'b0, 1, 0, 0, 1);
        check("b2b_done_cycle", int'(done), 1);
        run_cmp("b2b_second", 8'h01, 8'h00, 1'b0, 4, 1, 0, 0);
        step();

        // Reset two edges into a 4-cycle compare aborts it silently.
        start = 1'b1; a = 8'h5A; b = 8'h5A; signed_mode = 1'b0;
        step();
        start = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_g", int'(g), 0);
        check("abort_e", int'(e), 0);
        check("abort_l", int'(l), 0);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (done) pulses++;
        end
        check("abort_no_done", pulses, 0);
        run_cmp("post_rst_7f_80_s", 8'h7F, 8'h80, 1'b1, 1, 1, 0, 0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
